// File: rtl/if_stage_if.sv
// Bundle of signals between the fetch stage, the instruction ROM, the
// decode stage and the pipeline control (stall / branch / flush).
interface if_stage_if;
  // Instruction ROM fetch port
  logic [31:0] rom_addr_o;
  logic        rom_ce_o;
  logic [31:0] rom_data_i;

  // Pipeline control from decode / exception logic
  logic        stall_if_i;
  logic        stall_id_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        flush_i;
  logic [31:0] new_pc_i;

  // IF/ID register contents presented to decode
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;

  // Fetch stage side
  modport master (
    output rom_addr_o,
    output rom_ce_o,
    input  rom_data_i,
    input  stall_if_i,
    input  stall_id_i,
    input  branch_flag_i,
    input  branch_target_i,
    input  flush_i,
    input  new_pc_i,
    output id_pc_o,
    output id_inst_o,
    output id_valid_o
  );

  // Environment side: ROM, decode stage and pipeline control
  modport slave (
    input  rom_addr_o,
    input  rom_ce_o,
    output rom_data_i,
    output stall_if_i,
    output stall_id_i,
    output branch_flag_i,
    output branch_target_i,
    output flush_i,
    output new_pc_i,
    input  id_pc_o,
    input  id_inst_o,
    input  id_valid_o
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch front end: program counter, ROM fetch port and the
// IF/ID pipeline register. Branches follow MIPS delay-slot semantics (the
// instruction in IF when the branch resolves is never squashed); a flush
// redirects the PC and inserts a bubble into decode.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic      clk,
  input logic      rst,
  if_stage_if.master bus
);

  // Architectural state
  logic [31:0] r_pc;
  logic        r_ce;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_inst;
  logic        r_id_valid;

  // Next-state values
  logic [31:0] w_pc_next;
  logic [31:0] w_id_pc_next;
  logic [31:0] w_id_inst_next;
  logic        w_id_valid_next;

  // Word-aligned redirect targets; the low address bits are dropped
  logic [31:0] w_flush_pc;
  logic [31:0] w_branch_pc;
  logic [31:0] w_seq_pc;

  assign w_flush_pc  = {bus.new_pc_i[31:2], 2'b00};
  assign w_branch_pc = {bus.branch_target_i[31:2], 2'b00};
  assign w_seq_pc    = r_pc + 32'd4;

  // Byte-offset bits of redirect addresses are intentionally ignored
  logic unused_low_bits;
  assign unused_low_bits = ^{bus.new_pc_i[1:0], bus.branch_target_i[1:0]};

  // PC next-state: flush beats stall beats branch beats sequential fetch.
  // The PC is frozen while the chip enable has not yet come up, so the
  // first fetch after reset is RESET_PC.
  always_comb begin
    w_pc_next = r_pc;
    if (r_ce) begin
      if (bus.flush_i) begin
        w_pc_next = w_flush_pc;
      end else if (bus.stall_if_i) begin
        w_pc_next = r_pc;
      end else if (bus.branch_flag_i) begin
        w_pc_next = w_branch_pc;
      end else begin
        w_pc_next = w_seq_pc;
      end
    end
  end

  // IF/ID next-state: bubbles on flush, on an IF-only stall and before the
  // first fetch; hold on a decode stall; otherwise capture the fetched word.
  always_comb begin
    w_id_pc_next    = r_id_pc;
    w_id_inst_next  = r_id_inst;
    w_id_valid_next = r_id_valid;
    if (bus.flush_i) begin
      w_id_pc_next    = 32'd0;
      w_id_inst_next  = 32'd0;
      w_id_valid_next = 1'b0;
    end else if (bus.stall_id_i) begin
      w_id_pc_next    = r_id_pc;
      w_id_inst_next  = r_id_inst;
      w_id_valid_next = r_id_valid;
    end else if (bus.stall_if_i || !r_ce) begin
      w_id_pc_next    = 32'd0;
      w_id_inst_next  = 32'd0;
      w_id_valid_next = 1'b0;
    end else begin
      w_id_pc_next    = r_pc;
      w_id_inst_next  = bus.rom_data_i;
      w_id_valid_next = 1'b1;
    end
  end

  // PC and chip-enable registers; reset discards any pending redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
      r_ce <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      r_ce <= 1'b1;
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_pc    <= 32'd0;
      r_id_inst  <= 32'd0;
      r_id_valid <= 1'b0;
    end else begin
      r_id_pc    <= w_id_pc_next;
      r_id_inst  <= w_id_inst_next;
      r_id_valid <= w_id_valid_next;
    end
  end

  assign bus.rom_addr_o = r_pc;
  assign bus.rom_ce_o   = r_ce;
  assign bus.id_pc_o    = r_id_pc;
  assign bus.id_inst_o  = r_id_inst;
  assign bus.id_valid_o = r_id_valid;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by randomized control
// traffic, all compared against a cycle-level reference model of the fetch
// stage built from the architectural rules.
module tb_if_stage;

  logic clk;
  logic rst;

  if_stage_if bus ();

  if_stage #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction ROM contents: word i holds 0x3400_0000 + i
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return 32'h3400_0000 + (addr >> 2);
  endfunction

  assign bus.rom_data_i = bus.rom_ce_o ? rom_word(bus.rom_addr_o) : 32'd0;

  int unsigned n_total;
  int unsigned n_bad;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_pc;
  logic        m_ce;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_inst;
  logic        m_id_valid;

  // Advance one clock: compute model next state from current inputs, take
  // the edge, then compare every output 1 time unit later.
  task automatic step();
    logic [31:0] n_pc;
    logic        n_ce;
    logic [31:0] n_id_pc;
    logic [31:0] n_id_inst;
    logic        n_id_valid;
    n_pc       = m_pc;
    n_ce       = m_ce;
    n_id_pc    = m_id_pc;
    n_id_inst  = m_id_inst;
    n_id_valid = m_id_valid;
    if (rst) begin
      n_pc = 32'h0000_0000;
      n_ce = 1'b0;
      n_id_pc = 32'd0;
      n_id_inst = 32'd0;
      n_id_valid = 1'b0;
    end else begin
      n_ce = 1'b1;
      if (m_ce) begin
        if (bus.flush_i) n_pc = bus.new_pc_i & 32'hFFFF_FFFC;
        else if (bus.stall_if_i) n_pc = m_pc;
        else if (bus.branch_flag_i) n_pc = bus.branch_target_i & 32'hFFFF_FFFC;
        else n_pc = m_pc + 32'd4;
      end
      if (bus.flush_i || (!bus.stall_id_i && (bus.stall_if_i || !m_ce))) begin
        n_id_pc = 32'd0;
        n_id_inst = 32'd0;
        n_id_valid = 1'b0;
      end else if (!bus.stall_id_i) begin
        n_id_pc = m_pc;
        n_id_inst = rom_word(m_pc);
        n_id_valid = 1'b1;
      end
    end
    @(posedge clk);
    m_pc = n_pc;
    m_ce = n_ce;
    m_id_pc = n_id_pc;
    m_id_inst = n_id_inst;
    m_id_valid = n_id_valid;
    #1;
    check_eq("rom_addr", bus.rom_addr_o, m_pc);
    check_eq("rom_ce", {31'd0, bus.rom_ce_o}, {31'd0, m_ce});
    check_eq("id_pc", bus.id_pc_o, m_id_pc);
    check_eq("id_inst", bus.id_inst_o, m_id_inst);
    check_eq("id_valid", {31'd0, bus.id_valid_o}, {31'd0, m_id_valid});
  endtask

  task automatic clear_ctrl();
    bus.stall_if_i      = 1'b0;
    bus.stall_id_i      = 1'b0;
    bus.branch_flag_i   = 1'b0;
    bus.branch_target_i = 32'd0;
    bus.flush_i         = 1'b0;
    bus.new_pc_i        = 32'd0;
  endtask

  // Step until the model PC reaches the target, bounded by a cycle budget
  task automatic run_to(input logic [31:0] target);
    int k;
    k = 0;
    while (m_pc != target && k < 64) begin
      step();
      k++;
    end
    check_eq("reach_pc", m_pc, target);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    m_pc = 32'd0; m_ce = 1'b0; m_id_pc = 32'd0; m_id_inst = 32'd0; m_id_valid = 1'b0;
    clear_ctrl();
    rst = 1'b1;

    // Reset held for three cycles
    repeat (3) step();
    check_eq("rst_ce", {31'd0, bus.rom_ce_o}, 32'd0);
    check_eq("rst_valid", {31'd0, bus.id_valid_o}, 32'd0);

    // Release: chip enable rises, first fetch at RESET_PC
    rst = 1'b0;
    step();
    check_eq("rel_ce", {31'd0, bus.rom_ce_o}, 32'd1);
    check_eq("rel_addr0", bus.rom_addr_o, 32'h0);
    check_eq("rel_valid0", {31'd0, bus.id_valid_o}, 32'd0);
    step();
    check_eq("rel_addr4", bus.rom_addr_o, 32'h4);
    check_eq("rel_inst0", bus.id_inst_o, 32'h3400_0000);
    step();
    check_eq("rel_addr8", bus.rom_addr_o, 32'h8);
    check_eq("rel_inst1", bus.id_inst_o, 32'h3400_0001);

    // Combined stall at pc=0x10
    run_to(32'h10);
    bus.stall_if_i = 1'b1;
    bus.stall_id_i = 1'b1;
    repeat (2) begin
      step();
      check_eq("stall_pc", bus.rom_addr_o, 32'h10);
      check_eq("stall_inst", bus.id_inst_o, 32'h3400_0003);
    end
    bus.stall_id_i = 1'b0;
    step();
    check_eq("bub_valid", {31'd0, bus.id_valid_o}, 32'd0);
    check_eq("bub_inst", bus.id_inst_o, 32'd0);
    check_eq("bub_pc", bus.rom_addr_o, 32'h10);
    clear_ctrl();

    // Branch with delay slot at pc=0x20
    run_to(32'h20);
    bus.branch_flag_i   = 1'b1;
    bus.branch_target_i = 32'h0000_0100;
    step();
    check_eq("br_addr", bus.rom_addr_o, 32'h100);
    check_eq("br_slot_pc", bus.id_pc_o, 32'h20);
    check_eq("br_slot_inst", bus.id_inst_o, 32'h3400_0008);
    clear_ctrl();
    step();
    check_eq("br_tgt_pc", bus.id_pc_o, 32'h100);
    check_eq("br_tgt_inst", bus.id_inst_o, 32'h3400_0040);

    // Flush overrides branch and stall
    bus.flush_i         = 1'b1;
    bus.new_pc_i        = 32'h0000_0180;
    bus.branch_flag_i   = 1'b1;
    bus.branch_target_i = 32'h0000_0200;
    bus.stall_if_i      = 1'b1;
    step();
    check_eq("fl_addr", bus.rom_addr_o, 32'h180);
    check_eq("fl_valid", {31'd0, bus.id_valid_o}, 32'd0);
    check_eq("fl_inst", bus.id_inst_o, 32'd0);
    check_eq("fl_pc", bus.id_pc_o, 32'd0);
    clear_ctrl();
    step();

    // Misaligned branch near the top of the address space, then wrap
    bus.branch_flag_i   = 1'b1;
    bus.branch_target_i = 32'hFFFF_FFFE;
    step();
    check_eq("wrap_top", bus.rom_addr_o, 32'hFFFF_FFFC);
    clear_ctrl();
    step();
    check_eq("wrap_zero", bus.rom_addr_o, 32'h0);
    check_eq("wrap_idpc", bus.id_pc_o, 32'hFFFF_FFFC);

    // Reset mid-run while stalled with a pending branch
    step();
    bus.stall_if_i      = 1'b1;
    bus.stall_id_i      = 1'b1;
    bus.branch_flag_i   = 1'b1;
    bus.branch_target_i = 32'h0000_0300;
    rst = 1'b1;
    step();
    check_eq("mrst_addr", bus.rom_addr_o, 32'h0);
    check_eq("mrst_ce", {31'd0, bus.rom_ce_o}, 32'd0);
    check_eq("mrst_valid", {31'd0, bus.id_valid_o}, 32'd0);
    rst = 1'b0;
    clear_ctrl();
    step();
    check_eq("mrst_ce1", {31'd0, bus.rom_ce_o}, 32'd1);
    check_eq("mrst_addr0", bus.rom_addr_o, 32'h0);
    step();
    check_eq("mrst_addr4", bus.rom_addr_o, 32'h4);
    check_eq("mrst_inst", bus.id_inst_o, 32'h3400_0000);

    // Randomized control traffic
    for (int i = 0; i < 3000; i++) begin
      rst                 = ($urandom_range(0, 99) == 0);
      bus.flush_i         = ($urandom_range(0, 15) == 0);
      bus.new_pc_i        = $urandom;
      bus.stall_if_i      = ($urandom_range(0, 3) == 0);
      bus.stall_id_i      = bus.stall_if_i ? ($urandom_range(0, 1) == 1)
                                           : ($urandom_range(0, 31) == 0);
      bus.branch_flag_i   = ($urandom_range(0, 3) == 0);
      bus.branch_target_i = ($urandom_range(0, 1) == 1) ? $urandom
                                                        : {20'd0, 12'($urandom)};
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch front end for yangmips: owns the program counter and the IF/ID pipeline register.
- Drives the instruction-ROM fetch interface (address + chip enable) and consumes the returned instruction word.
- Hands {pc, inst, valid} to the decode stage.
- Handles pipeline stalls, branch redirects (MIPS delay-slot semantics) and exception flushes.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; low two bits must be 00.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- rom_addr_o  output  32  byte address of instruction being fetched (= PC)
- rom_ce_o  output  1  ROM chip enable; ROM returns 0 when low
- rom_data_i  input  32  instruction word; combinational from ROM in the same cycle as rom_addr_o
- stall_if_i  input  1  hold PC this cycle
- stall_id_i  input  1  decode stage stalled; hold IF/ID register
- branch_flag_i  input  1  branch/jump resolved taken in ID this cycle
- branch_target_i  input  32  branch/jump target address
- flush_i  input  1  exception/eret flush
- new_pc_i  input  32  redirect address accompanying flush_i
- id_pc_o  output  32  PC of instruction presented to decode
- id_inst_o  output  32  instruction presented to decode
- id_valid_o  output  1  id_inst_o is a real fetched instruction, not a bubble

Behaviour:
- Reset (rst=1 at a clock edge), all registered:
  - pc=RESET_PC, rom_ce_o=0
  - id_pc_o=0, id_inst_o=0, id_valid_o=0
- rom_ce_o rises to 1 on the first edge with rst=0. PC stays RESET_PC on that edge, so the first fetch address is RESET_PC.
- rom_addr_o = pc (combinational from the PC register). There is no internal address translation.
- PC update when rom_ce_o=1, priority high to low:
  1. flush_i=1: pc <= {new_pc_i[31:2],2'b00}. Overrides stalls and branches.
  2. stall_if_i=1: pc holds.
  3. branch_flag_i=1: pc <= {branch_target_i[31:2],2'b00}.
  4. otherwise: pc <= pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- The branch must stay asserted by ID until the stall clears. A branch arriving while stall_if_i=1 is not latched.
- Delay slot: the instruction in IF during the cycle branch_flag_i=1 is the delay slot. It advances to ID normally and is never squashed by a branch.
- IF/ID register update, priority high to low:
  1. flush_i=1: load bubble (pc 0, inst 0, valid 0).
  2. stall_id_i=1: hold all three outputs.
  3. stall_if_i=1 and stall_id_i=0: load bubble.
  4. rom_ce_o=0: load bubble.
  5. otherwise: id_pc_o<=pc, id_inst_o<=rom_data_i, id_valid_o<=1.
- Latency: the instruction at address A appears on id_inst_o exactly one edge after rom_addr_o=A with no stall.
- Reset mid-operation overrides everything: pending branch, stall and flush state are discarded, and the block restarts from RESET_PC with rom_ce_o low for one cycle.
- stall_id_i=1 with stall_if_i=0 is illegal upstream. If it occurs, the PC still advances per the rules above and the skipped instruction is lost. The block does not detect this condition.
- No internal FSM beyond the ce_started bit (rom_ce_o); no buffering beyond the single IF/ID register.

Test Plan:
- Reset release: rst high 3 cycles then low, ROM word[i]=0x3400_0000+i.
  - rom_ce_o is 0 during reset and 1 from the first post-reset edge.
  - rom_addr_o sequence 0x0,0x4,0x8,… with id_inst_o 0x3400_0000, 0x3400_0001 one cycle later.
  - id_valid_o is 0 until the first instruction arrives.
- Stall: assert stall_if_i=stall_id_i=1 for 2 cycles at pc=0x10.
  - pc holds 0x10 and IF/ID holds the 0xC instruction.
  - Then stall_id_i=0, stall_if_i=1 for 1 cycle: id_valid_o=0, id_inst_o=0 bubble, pc still 0x10.
- Branch with delay slot: branch_flag_i=1, target 0x0000_0100 while pc=0x20.
  - Next rom_addr_o is 0x100.
  - The 0x20 instruction appears in ID, then the 0x100 instruction follows.
- Flush: flush_i=1, new_pc_i=0x0000_0180, together with branch_flag_i=1 and stall_if_i=1.
  - pc becomes 0x180.
  - IF/ID becomes a bubble (valid 0, inst 0, pc 0).
- Wrap and alignment:
  - branch to 0xFFFF_FFFE: pc becomes 0xFFFF_FFFC, then 0x0000_0000.
- Mid-run reset: rst=1 for one cycle while stalled with branch_flag_i=1.
  - pc=RESET_PC, rom_ce_o=0, id_valid_o=0.
  - Fetch resumes at RESET_PC.
